// File: rtl/cmd_conditioner.sv
// cmd_conditioner: conditions raw push-buttons and switches into one-cycle
// load/up/down command pulses plus a registered load value for the counter.
// Per channel: 2-flop synchroniser, debounce filter, rising-edge detector,
// then a fixed-priority arbiter (load > up > down).
// Optional macro HOLD_REPEAT_EN: up/down auto-repeat while the button is held.
module cmd_conditioner #(
    parameter int unsigned DATA_WIDTH      = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_PERIOD   = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_btn_up,
    input  logic                  i_btn_down,
    input  logic                  i_btn_load,
    input  logic [DATA_WIDTH-1:0] i_sw,
    output logic                  o_load,
    output logic                  o_up,
    output logic                  o_down,
    output logic [DATA_WIDTH-1:0] o_load_data
);

    localparam int unsigned NCH     = 3;
    localparam int unsigned CH_LOAD = 0;
    localparam int unsigned CH_UP   = 1;
    localparam int unsigned CH_DOWN = 2;
    localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [NCH-1:0]        btn_raw;
    logic [NCH-1:0]        btn_s1;
    logic [NCH-1:0]        btn_s2;
    logic [NCH-1:0]        db;
    logic [NCH-1:0]        db_d;
    logic [CNT_W-1:0]      cnt [NCH];
    logic [DATA_WIDTH-1:0] sw_s1;
    logic [DATA_WIDTH-1:0] sw_s2;
    logic [NCH-1:0]        edge_c;
    logic [NCH-1:0]        req_c;

    assign btn_raw = {i_btn_down, i_btn_up, i_btn_load};

    // Two-flop synchronisers for buttons and switch bus
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= i_sw;
            sw_s2  <= sw_s1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES stable cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            db_d <= db;
            for (int i = 0; i < NCH; i++) begin
                if (btn_s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]  <= btn_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign edge_c = db & ~db_d;

`ifdef HOLD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt [2];
    logic [1:0]       rep_first;
    logic [1:0]       rep_fire_c;

    // Repeat request once the held time reaches the initial delay, then each period
    always_comb begin
        rep_fire_c = '0;
        for (int j = 0; j < 2; j++) begin
            rep_fire_c[j] = db[j+1] && db_d[j+1] &&
                (rep_cnt[j] == (rep_first[j] ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD)));
        end
    end

    // Per-channel hold timer for up/down; cleared whenever the debounced level is low
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rep_first <= '1;
            for (int j = 0; j < 2; j++) rep_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!db[j+1]) begin
                    rep_cnt[j]   <= '0;
                    rep_first[j] <= 1'b1;
                end else if (edge_c[j+1]) begin
                    rep_cnt[j]   <= REP_W'(1);
                    rep_first[j] <= 1'b1;
                end else if (rep_fire_c[j]) begin
                    rep_cnt[j]   <= REP_W'(1);
                    rep_first[j] <= 1'b0;
                end else begin
                    rep_cnt[j]   <= rep_cnt[j] + REP_W'(1);
                end
            end
        end
    end

    assign req_c = edge_c | {rep_fire_c, 1'b0};
`else
    assign req_c = edge_c;
`endif

    // Priority arbiter and registered command outputs; losers are dropped
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_load      <= 1'b0;
            o_up        <= 1'b0;
            o_down      <= 1'b0;
            o_load_data <= '0;
        end else begin
            o_load <= req_c[CH_LOAD];
            o_up   <= req_c[CH_UP] & ~req_c[CH_LOAD];
            o_down <= req_c[CH_DOWN] & ~req_c[CH_UP] & ~req_c[CH_LOAD];
            if (req_c[CH_LOAD]) o_load_data <= sw_s2;
        end
    end

endmodule

// File: tb/tb_cmd_conditioner.sv
// tb_cmd_conditioner: directed-vector bench for cmd_conditioner (D=16).
// Edge 0 is the first posedge after an input change; outputs are sampled
// 1 time unit after each posedge and logged by edge index.
module tb_cmd_conditioner;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_btn_up;
    logic       i_btn_down;
    logic       i_btn_load;
    logic [4:0] i_sw;
    logic       o_load;
    logic       o_up;
    logic       o_down;
    logic [4:0] o_load_data;

    int errors = 0;
    int checks = 0;

    int first_up, first_down, first_load;
    int n_up, n_down, n_load, n_multi;
    int ld_at_pulse;
    int up_edges[$];

    cmd_conditioner #(
        .DATA_WIDTH(5),
        .DEBOUNCE_CYCLES(16),
        .REPEAT_DELAY(50),
        .REPEAT_PERIOD(10)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_btn_up(i_btn_up),
        .i_btn_down(i_btn_down),
        .i_btn_load(i_btn_load),
        .i_sw(i_sw),
        .o_load(o_load),
        .o_up(o_up),
        .o_down(o_down),
        .o_load_data(o_load_data)
    );

    always #5 i_clk = ~i_clk;

    // Count one comparison and report it if it mismatches
    task automatic check_eq(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance n clock edges, logging pulse positions and counts
    task automatic run(input int n);
        first_up = -1; first_down = -1; first_load = -1;
        n_up = 0; n_down = 0; n_load = 0; n_multi = 0;
        ld_at_pulse = -1;
        up_edges.delete();
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
            if (o_up === 1'b1) begin
                if (first_up < 0) first_up = k;
                n_up++;
                up_edges.push_back(k);
            end
            if (o_down === 1'b1) begin
                if (first_down < 0) first_down = k;
                n_down++;
            end
            if (o_load === 1'b1) begin
                if (first_load < 0) first_load = k;
                n_load++;
                ld_at_pulse = int'(o_load_data);
            end
            if ((int'(o_load === 1'b1) + int'(o_up === 1'b1) + int'(o_down === 1'b1)) > 1)
                n_multi++;
        end
    endtask

    initial begin
        i_rst = 1'b1; i_btn_up = 1'b0; i_btn_down = 1'b0; i_btn_load = 1'b0; i_sw = 5'd0;
        run(3);
        check_eq("rst_outputs", {o_load, o_up, o_down}, 0);
        check_eq("rst_load_data", int'(o_load_data), 0);
        i_rst = 1'b0;
        run(5);

        // Up held: single pulse at edge 18
        i_btn_up = 1'b1;
        run(30);
        check_eq("up_first", first_up, 18);
        check_eq("up_count", n_up, 1);
        check_eq("up_no_down_load", n_down + n_load, 0);
        i_btn_up = 1'b0;
        run(30);
        check_eq("up_release_nopulse", n_up, 0);

        // Down bounce: high 5, low 3, high 7, low 3 then held
        i_btn_down = 1'b1; run(5);
        check_eq("bounce_a", n_down, 0);
        i_btn_down = 1'b0; run(3);
        check_eq("bounce_b", n_down, 0);
        i_btn_down = 1'b1; run(7);
        check_eq("bounce_c", n_down, 0);
        i_btn_down = 1'b0; run(3);
        check_eq("bounce_d", n_down, 0);
        i_btn_down = 1'b1; run(30);
        check_eq("down_first", first_down, 18);
        check_eq("down_count", n_down, 1);
        i_btn_down = 1'b0; run(30);
        check_eq("down_release", n_down, 0);

        // Load with static switches, then switches change after release
        i_sw = 5'd19; i_btn_load = 1'b1;
        run(30);
        check_eq("load_first", first_load, 18);
        check_eq("load_count", n_load, 1);
        check_eq("load_data_pulse", ld_at_pulse, 19);
        i_btn_load = 1'b0;
        run(10);
        i_sw = 5'd7;
        run(30);
        check_eq("load_data_hold", int'(o_load_data), 19);
        check_eq("load_release", n_load, 0);

        // Load and up together: load wins, up dropped
        i_sw = 5'd3; i_btn_load = 1'b1; i_btn_up = 1'b1;
        run(30);
        check_eq("prio_load_count", n_load, 1);
        check_eq("prio_load_first", first_load, 18);
        check_eq("prio_up_dropped", n_up, 0);
        check_eq("prio_onehot", n_multi, 0);
        check_eq("prio_load_data", int'(o_load_data), 3);
        i_btn_load = 1'b0; i_btn_up = 1'b0;
        run(30);

        // Up and down together: only up
        i_btn_up = 1'b1; i_btn_down = 1'b1;
        run(30);
        check_eq("updown_up", n_up, 1);
        check_eq("updown_down", n_down, 0);
        i_btn_up = 1'b0; i_btn_down = 1'b0;
        run(30);

        // Reset mid-debounce with up held
        i_btn_up = 1'b1;
        run(11);
        check_eq("pre_rst_nopulse", n_up, 0);
        i_rst = 1'b1;
        run(2);
        check_eq("mid_rst_outputs", {o_load, o_up, o_down}, 0);
        check_eq("mid_rst_load_data", int'(o_load_data), 0);
        i_rst = 1'b0;
        run(30);
        check_eq("post_rst_up_first", first_up, 18);
        check_eq("post_rst_up_count", n_up, 1);
        i_btn_up = 1'b0;
        run(30);

`ifdef HOLD_REPEAT_EN
        // Auto-repeat: pulses at 18, 68, 78, 88, 98 within the hold window
        i_btn_up = 1'b1;
        run(100);
        check_eq("rep_count", n_up, 5);
        if (up_edges.size() == 5) begin
            check_eq("rep_0", up_edges[0], 18);
            check_eq("rep_1", up_edges[1], 68);
            check_eq("rep_2", up_edges[2], 78);
            check_eq("rep_3", up_edges[3], 88);
            check_eq("rep_4", up_edges[4], 98);
        end
        i_btn_up = 1'b0;
        run(40);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
